decim_integrate_dump: RTL
=========================

// Module: decim_integrate_dump
// PURPOSE
//  Decimating integrate-and-dump stage directly downstream of the front low-pass filter in the downmixer.
//  Takes the filtered baseband at MIXING_FREQ and sums R = MIXING_FREQ/DEMOD_FREQ consecutive samples.
//  Emits one scaled, saturated sample per R inputs at DEMOD_FREQ, with a one-clock out_valid strobe.
//  Output feeds the demodulator stage.
// PARAMETERS
//  DATA_WIDTH    16         width of sample_in / sample_out, two's complement
//  SYS_CLK_FREQ  6_400_000  clk frequency, Hz
//  MIXING_FREQ   320_000    input sample rate, Hz; DIV = SYS_CLK_FREQ/MIXING_FREQ = 20
//  DEMOD_FREQ    16_000     output sample rate, Hz; R = MIXING_FREQ/DEMOD_FREQ = 20
//  SHIFT         4          arithmetic right shift applied to the dump sum (gain R/2^SHIFT)
// PORTS
//  clk         in   1           system clock
//  rst         in   1           asynchronous reset, active low
//  start       in   1           run enable; low = hold idle, discard partial sum
//  sample_in   in   DATA_WIDTH  signed filtered sample, stable for >= 1 DIV period
//  sample_out  out  DATA_WIDTH  signed decimated sample, held between dumps
//  out_valid   out  1           one-clock pulse when sample_out updates
//  sat         out  1           high with out_valid if that dump saturated; else 0
// BEHAVIOUR
//  Reset (rst=0, async): div_cnt, dec_cnt, acc, sample_out, out_valid, sat all cleared to 0.
//  Clock-enable: div_cnt counts 0..DIV-1 and wraps. sample_en = (div_cnt==DIV-1) && start.
//   This matches the upstream filter cadence.
//  start=0: div_cnt, dec_cnt and acc forced to 0 on the next edge; out_valid=0; sample_out holds.
//  Accumulate: on an edge with sample_en:
//   - dec_cnt < R-1: acc <= acc + sext(sample_in); dec_cnt++.
//  Dump: on an edge with sample_en and dec_cnt==R-1:
//   - sum = acc + sample_in (ACC_WIDTH = DATA_WIDTH + clog2(R) = 21 bits; no internal overflow).
//   - s = sum >>> SHIFT (arithmetic, truncate toward -inf).
//   - Clamp s to [-2^(DW-1), 2^(DW-1)-1]. sample_out <= clamped s; sat <= (clamp active).
//   - out_valid <= 1; acc <= 0; dec_cnt <= 0.
//  Latency: out_valid rises on the same edge that absorbs the R-th sample.
//   With start held, the first dump is at the (R*DIV)=400th edge after start first seen high.
//   Subsequent dumps follow every 400 clocks.
//  out_valid and sat are single-cycle: cleared on the next edge unconditionally.
//  start falling mid-frame: partial sum is dropped and no dump occurs. When start rises again,
//   the frame starts from dec_cnt=0 with full DIV alignment restart.
//  start falling on the dump edge: the dump completes (start sampled high on that edge).
//  Reset mid-frame: immediate clear, no output pulse; restart as from power-up.
//  Width rule: all arithmetic is signed; sample_in is sign-extended to ACC_WIDTH before the add.
// STRUCTURE
//  Shared header downmixer_defs.vh: SYS_CLK_FREQ, MIXING_FREQ, DEMOD_FREQ defaults, derived DIV, R,
//   and the clog2-based ACC_WIDTH macro. The front LP filter uses the same header.
//  One sub-module: ce_divider (parameter DIV; ports clk, rst, clr, ce). It generates sample_en and is
//   reusable by the filter stage. Accumulator, dump, scale and saturate logic stays in this module.
// TESTING
//  1 Const 1000, start=1: out_valid every 400 clk; sample_out=20000>>>4=1250, sat=0.
//  2 Const 32767: sum 655340>>>4=40958 -> sample_out=32767, sat=1. Const -32768: -40960 -> -32768, sat=1.
//  3 Alternating +1000/-1000 per sample_en: sample_out=0 each dump, sat=0.
//  4 start=0 after 10 samples of 1000, then start=1 with const 200: no pulse while low;
//    next dump = 4000>>>4=250 (no residue).
//  5 rst=0 asserted mid-frame between clock edges: sample_out/out_valid/sat are 0 immediately.
//    After release, first dump at clock 400.
//  6 Const -1: sum -20>>>4 = -2 (floor rounding checked); pulse width exactly 1 clk.

Source files
------------

// File: rtl/decim_integrate_dump_pkg.sv
// Shared downmixer rate defaults and width helpers, common to the front filter and the decimator.
package decim_integrate_dump_pkg;

    localparam int DEF_SYS_CLK_FREQ = 6_400_000;
    localparam int DEF_MIXING_FREQ  = 320_000;
    localparam int DEF_DEMOD_FREQ   = 16_000;

    // Accumulator wide enough that r full-scale samples cannot overflow.
    function automatic int acc_width(input int data_width, input int r);
        return data_width + $clog2(r);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Free-running clock-enable divider: ce is high for one clk every DIV clocks; clr restarts the phase.
module ce_divider #(
    parameter int DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic ce
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (clr || div_cnt == CW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    assign ce = (div_cnt == CW'(DIV - 1));

endmodule

// File: rtl/decim_integrate_dump.sv
// Integrate-and-dump decimator: sums R input samples, emits one scaled, saturated sample per frame.
module decim_integrate_dump
    import decim_integrate_dump_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int SYS_CLK_FREQ = DEF_SYS_CLK_FREQ,
    parameter int MIXING_FREQ  = DEF_MIXING_FREQ,
    parameter int DEMOD_FREQ   = DEF_DEMOD_FREQ,
    parameter int SHIFT        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] sample_in,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         out_valid,
    output logic                         sat
);

    localparam int DIV       = SYS_CLK_FREQ / MIXING_FREQ;
    localparam int R         = MIXING_FREQ / DEMOD_FREQ;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, R);
    localparam int CNT_W     = (R > 1) ? $clog2(R) : 1;

    localparam logic signed [ACC_WIDTH-1:0] MAX_S =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_S =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                         ce;
    logic                         clr;
    logic                         sample_en;
    logic [CNT_W-1:0]             dec_cnt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  scaled;
    logic signed [DATA_WIDTH-1:0] dump_val;
    logic                         dump_sat;

    assign clr       = ~start;
    assign sample_en = ce && start;

    ce_divider #(.DIV(DIV)) u_ce (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ce  (ce)
    );

    // Scale with floor rounding, then clamp to the output range.
    always_comb begin
        sum      = acc + {{(ACC_WIDTH-DATA_WIDTH){sample_in[DATA_WIDTH-1]}}, sample_in};
        scaled   = sum >>> SHIFT;
        dump_val = scaled[DATA_WIDTH-1:0];
        dump_sat = 1'b0;
        if (scaled > MAX_S) begin
            dump_val = MAX_S[DATA_WIDTH-1:0];
            dump_sat = 1'b1;
        end else if (scaled < MIN_S) begin
            dump_val = MIN_S[DATA_WIDTH-1:0];
            dump_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_cnt    <= '0;
            acc        <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            sat        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            if (!start) begin
                dec_cnt <= '0;
                acc     <= '0;
            end else if (sample_en) begin
                if (dec_cnt == CNT_W'(R - 1)) begin
                    sample_out <= dump_val;
                    sat        <= dump_sat;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    dec_cnt    <= '0;
                end else begin
                    acc     <= sum;
                    dec_cnt <= dec_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
